// File: rtl/alu_op_decode_stage.sv
// ID/EX decode stage: RV32I instruction -> ALU op, immediate and control.
// One-cycle latency, stall/flush support, saturating illegal-op counter.
module alu_op_decode_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       alu_op,
  output logic             use_imm,
  output logic [31:0]      imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             reg_write,
  output logic             is_branch,
  output logic             br_inv,
  output logic             illegal,
  output logic             out_valid,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic        br_inv;
    logic        illegal;
    logic        out_valid;
  } dec_t;

  dec_t d;
  dec_t q;
  logic [CNT_W-1:0] cnt;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        rd_nz;
  logic        is_op;
  logic        is_opi;
  logic        is_lui;
  logic        is_ld;
  logic        is_st;
  logic        is_br;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_sh;

  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd_nz  = instr[11:7] != 5'd0;

  assign is_op  = opc == 7'b0110011;
  assign is_opi = opc == 7'b0010011;
  assign is_lui = opc == 7'b0110111;
  assign is_ld  = opc == 7'b0000011;
  assign is_st  = opc == 7'b0100011;
  assign is_br  = opc == 7'b1100011;

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    d           = '0;
    d.rs1       = instr[19:15];
    d.rs2       = instr[24:20];
    d.rd        = instr[11:7];
    d.out_valid = 1'b1;
    unique case (1'b1)
      is_op: begin
        if (f7 == 7'h00 ||
            (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          d.alu_op    = {f7[5], f3};
          d.reg_write = rd_nz;
        end else begin
          d.illegal = 1'b1;
        end
      end
      is_opi: begin
        if ((f3 == 3'b001 && f7 != 7'h00) ||
            (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) begin
          d.illegal = 1'b1;
        end else begin
          d.alu_op    = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
          d.imm       = (f3[1:0] == 2'b01) ? imm_sh : imm_i;
          d.use_imm   = 1'b1;
          d.reg_write = rd_nz;
        end
      end
      is_lui: begin
        d.alu_op    = 4'b1111;
        d.imm       = imm_u;
        d.use_imm   = 1'b1;
        d.reg_write = rd_nz;
      end
      is_ld: begin
        d.imm       = imm_i;
        d.use_imm   = 1'b1;
        d.reg_write = rd_nz;
      end
      is_st: begin
        d.imm     = imm_s;
        d.use_imm = 1'b1;
      end
      is_br: begin
        if (f3[2:1] == 2'b01) begin
          d.illegal = 1'b1;
        end else begin
          // f3[0] selects the inverted sense (bne/bge/bgeu)
          d.alu_op    = f3[2] ? {3'b001, f3[1]} : 4'b1001;
          d.br_inv    = f3[0];
          d.is_branch = 1'b1;
          d.imm       = imm_b;
        end
      end
      default: d.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else if (flush || (!stall && !instr_valid)) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
      if (d.illegal && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end

  assign alu_op      = q.alu_op;
  assign use_imm     = q.use_imm;
  assign imm         = q.imm;
  assign rs1         = q.rs1;
  assign rs2         = q.rs2;
  assign rd          = q.rd;
  assign reg_write   = q.reg_write;
  assign is_branch   = q.is_branch;
  assign br_inv      = q.br_inv;
  assign illegal     = q.illegal;
  assign out_valid   = q.out_valid;
  assign illegal_cnt = cnt;

endmodule

// File: tb/tb_alu_op_decode_stage.sv
// Bench for alu_op_decode_stage: per-cycle model compare plus
// directed literal checks; a second instance uses CNT_W=2.
module tb_alu_op_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic [3:0]  alu_op, alu_op2;
  logic        use_imm, use_imm2;
  logic [31:0] imm, imm2;
  logic [4:0]  rs1, rs2, rd, rs1_2, rs2_2, rd_2;
  logic        reg_write, is_branch, br_inv, illegal, out_valid;
  logic        reg_write2, is_branch2, br_inv2, illegal2, out_valid2;
  logic [7:0]  cnt8;
  logic [1:0]  cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_decode_stage #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .instr_valid(instr_valid), .stall(stall), .flush(flush),
    .alu_op(alu_op), .use_imm(use_imm), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
    .is_branch(is_branch), .br_inv(br_inv), .illegal(illegal),
    .out_valid(out_valid), .illegal_cnt(cnt8)
  );

  alu_op_decode_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .instr_valid(instr_valid), .stall(stall), .flush(flush),
    .alu_op(alu_op2), .use_imm(use_imm2), .imm(imm2),
    .rs1(rs1_2), .rs2(rs2_2), .rd(rd_2), .reg_write(reg_write2),
    .is_branch(is_branch2), .br_inv(br_inv2), .illegal(illegal2),
    .out_valid(out_valid2), .illegal_cnt(cnt2)
  );

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic        br_inv;
    logic        illegal;
    logic        out_valid;
  } o_t;

  o_t exp_o;
  int exp_c8;
  int exp_c2;

  // Spec-level decode: mnemonic class first, then fields.
  function automatic o_t model(input logic [31:0] i);
    o_t o;
    int f3, f7, op;
    bit ok;
    logic [31:0] sx;
    o = '0;
    op = int'(i[6:0]);
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    sx = {{20{i[31]}}, i[31:20]};
    o.rs1 = i[19:15];
    o.rs2 = i[24:20];
    o.rd = i[11:7];
    o.out_valid = 1'b1;
    ok = 1'b1;
    if (op == 'h33) begin
      ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      o.alu_op = 4'(f3 + (f7 == 32 ? 8 : 0));
    end else if (op == 'h13) begin
      if (f3 == 1) ok = (f7 == 0);
      if (f3 == 5) ok = (f7 == 0 || f7 == 32);
      o.alu_op = 4'(f3 + ((f3 == 5 && f7 == 32) ? 8 : 0));
      o.imm = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : sx;
      o.use_imm = 1'b1;
    end else if (op == 'h37) begin
      o.alu_op = 4'd15;
      o.imm = i & 32'hFFFFF000;
      o.use_imm = 1'b1;
    end else if (op == 'h03) begin
      o.imm = sx;
      o.use_imm = 1'b1;
    end else if (op == 'h23) begin
      o.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      o.use_imm = 1'b1;
    end else if (op == 'h63) begin
      o.is_branch = 1'b1;
      o.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      case (f3)
        0: begin o.alu_op = 4'd9; o.br_inv = 0; end
        1: begin o.alu_op = 4'd9; o.br_inv = 1; end
        4: begin o.alu_op = 4'd2; o.br_inv = 0; end
        5: begin o.alu_op = 4'd2; o.br_inv = 1; end
        6: begin o.alu_op = 4'd3; o.br_inv = 0; end
        7: begin o.alu_op = 4'd3; o.br_inv = 1; end
        default: ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
    o.reg_write = ok && (op != 'h23) && (op != 'h63) && (o.rd != 0);
    if (!ok) begin
      o.alu_op = '0;
      o.use_imm = 1'b0;
      o.imm = '0;
      o.reg_write = 1'b0;
      o.is_branch = 1'b0;
      o.br_inv = 1'b0;
      o.illegal = 1'b1;
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_o <= '0;
      exp_c8 <= 0;
      exp_c2 <= 0;
    end else if (flush || (!stall && !instr_valid)) begin
      exp_o <= '0;
    end else if (!stall) begin
      exp_o <= model(instr);
      if (model(instr).illegal) begin
        exp_c8 <= (exp_c8 < 255) ? exp_c8 + 1 : 255;
        exp_c2 <= (exp_c2 < 3) ? exp_c2 + 1 : 3;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic o_t act1();
    return {alu_op, use_imm, imm, rs1, rs2, rd, reg_write,
            is_branch, br_inv, illegal, out_valid};
  endfunction

  function automatic o_t act2();
    return {alu_op2, use_imm2, imm2, rs1_2, rs2_2, rd_2, reg_write2,
            is_branch2, br_inv2, illegal2, out_valid2};
  endfunction

  always @(negedge clk) begin
    check("model_outs", 64'(act1()), 64'(exp_o));
    check("model_outs2", 64'(act2()), 64'(exp_o));
    check("model_cnt8", 64'(cnt8), 64'(exp_c8));
    check("model_cnt2", 64'(cnt2), 64'(exp_c2));
  end

  task automatic step(input logic [31:0] i, input logic v,
                      input logic s, input logic f);
    instr = i;
    instr_valid = v;
    stall = s;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec [15] = '{
    32'h00209133, 32'h0020A1B3, 32'h0020B1B3, 32'h4020C1B3,
    32'h00109093, 32'h40109093, 32'hFFF00093, 32'h00012083,
    32'h00012003, 32'hFE112E23, 32'h0020C463, 32'h0020F463,
    32'h0020A463, 32'hFFFFFFFF, 32'h00000073
  };

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 64'(act1()), 64'd0);
    check("rst_cnt", 64'(cnt8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step(32'h002081B3, 1, 0, 0);
    check("add_alu", 64'(alu_op), 64'h0);
    check("add_regs", 64'({rs1, rs2, rd}), 64'({5'd1, 5'd2, 5'd3}));
    check("add_ctl", 64'({reg_write, use_imm, out_valid}), 64'b101);

    step(32'h402081B3, 1, 0, 0);
    check("sub_alu", 64'(alu_op), 64'h8);

    step(32'h40335293, 1, 0, 0);
    check("srai_alu", 64'(alu_op), 64'hD);
    check("srai_imm", 64'(imm), 64'd3);
    check("srai_ctl", 64'({use_imm, rd}), 64'({1'b1, 5'd5}));

    step(32'h123450B7, 1, 0, 0);
    check("lui_alu", 64'(alu_op), 64'hF);
    check("lui_imm", 64'(imm), 64'h12345000);

    step(32'hFE209EE3, 1, 0, 0);
    check("bne_alu", 64'(alu_op), 64'h9);
    check("bne_imm", 64'(imm), 64'hFFFFFFFC);
    check("bne_ctl", 64'({br_inv, is_branch, reg_write}), 64'b110);

    step(32'h002081B3, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(32'h402081B3, 1, 1, 0);
      check("stall_hold", 64'({alu_op, out_valid, rd}),
            64'({4'h0, 1'b1, 5'd3}));
    end
    step(32'h402081B3, 1, 1, 1);
    check("flush_stall", 64'({out_valid, alu_op}), 64'd0);

    for (int k = 0; k < 3; k++) begin
      step(32'h0, 1, 0, 0);
      check("ill_flag", 64'({illegal, out_valid, alu_op}),
            64'({1'b1, 1'b1, 4'h0}));
    end
    check("ill_cnt3", 64'(cnt8), 64'd3);
    step(32'h0, 1, 0, 0);
    step(32'h0, 1, 0, 0);
    check("ill_sat2", 64'(cnt2), 64'd3);
    check("ill_cnt5", 64'(cnt8), 64'd5);

    step(32'h0, 1, 0, 1);
    check("flush_cnt", 64'({cnt8, 7'd0, out_valid}), 64'({8'd5, 8'd0}));
    step(32'h0, 0, 0, 0);
    check("bubble", 64'({cnt8, 7'd0, out_valid}), 64'({8'd5, 8'd0}));

    step(32'hFFF00093, 1, 0, 0);
    check("addi_imm", 64'(imm), 64'hFFFFFFFF);

    foreach (vec[k]) step(vec[k], 1, 0, 0);
    step(32'h002081B3, 1, 0, 0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);

    #3 rst_n = 1'b0;
    #1;
    check("async_rst", 64'(act1()), 64'd0);
    check("async_cnt", 64'(cnt8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h002081B3, 1, 0, 0);
    check("post_rst_add", 64'({out_valid, rd}), 64'({1'b1, 5'd3}));
    step(32'h0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
